out_bcd_display: RTL and testbench

//  Consumer of the CPU 16-bit `out` port: detects a change of the output word, converts it
//  (unsigned) to BCD with a sequential shift-add-3 (double-dabble) engine, and drives

---
 rtl/out_bcd_display_if.sv | 14 +
 rtl/out_bcd_display.sv | 105 ++++++++++
 tb/tb_out_bcd_display.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/out_bcd_display_if.sv
// Display bus between the CPU out port (master) and the BCD/7-segment converter (slave).
interface out_bcd_display_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DIGITS     = 5
);
  logic [DATA_WIDTH-1:0] in;
  logic [4*DIGITS-1:0]   bcd;
  logic [7*DIGITS-1:0]   seg;
  logic                  busy;
  logic                  updated;

  modport master (output in, input bcd, seg, busy, updated);
  modport slave  (input in, output bcd, seg, busy, updated);
endinterface

// File: rtl/out_bcd_display.sv
// Watches the CPU out word, converts each new value to BCD with a sequential double-dabble
// engine and drives active-low 7-segment patterns for the board display.
module out_bcd_display #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned DIGITS        = 5,
  parameter int unsigned BLANK_LEADING = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  out_bcd_display_if.slave  bus
);
  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned SW = 7 * DIGITS;
  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // Per-digit decode; a leading digit is blanked while it and everything above it is zero.
  function automatic logic [SW-1:0] decode_all(input logic [BW-1:0] v);
    logic [SW-1:0] r;
    logic          lead;
    r    = '0;
    lead = 1'b1;
    for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
      if (v[4*k +: 4] != 4'd0) lead = 1'b0;
      if ((BLANK_LEADING != 0) && lead && (k != 0)) r[7*k +: 7] = 7'h7F;
      else                                          r[7*k +: 7] = seg7(v[4*k +: 4]);
    end
    return r;
  endfunction

  localparam logic [SW-1:0] SEG_RESET = decode_all('0);

  state_t                state;
  logic [DATA_WIDTH-1:0] last;
  logic [DATA_WIDTH-1:0] shift;
  logic [BW-1:0]         scratch;
  logic [BW-1:0]         adj;
  logic [CW-1:0]         cnt;

  // Add-3 correction per nibble; nibbles never exceed 9 so no inter-nibble carry exists.
  always_comb begin
    adj = scratch;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (scratch[4*k +: 4] >= 4'd5) adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
    end
  end

  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last        <= '0;
      shift       <= '0;
      scratch     <= '0;
      cnt         <= '0;
      bus.bcd     <= '0;
      bus.seg     <= SEG_RESET;
      bus.updated <= 1'b0;
    end else begin
      bus.updated <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in != last) begin
            last    <= bus.in;
            shift   <= bus.in;
            scratch <= '0;
            cnt     <= CW'(DATA_WIDTH);
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= {adj[BW-2:0], shift[DATA_WIDTH-1]};
          shift   <= {shift[DATA_WIDTH-2:0], 1'b0};
          cnt     <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= DONE;
        end
        DONE: begin
          bus.bcd     <= scratch;
          bus.seg     <= decode_all(scratch);
          bus.updated <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_out_bcd_display.sv
// Directed bench for out_bcd_display: blanked and unblanked instances driven from one clock.
module tb_out_bcd_display;
  logic clk;
  logic rst_n;
  int   vectors;
  int   errors;

  out_bcd_display_if #(.DATA_WIDTH(16), .DIGITS(5)) bus  ();
  out_bcd_display_if #(.DATA_WIDTH(16), .DIGITS(5)) bus2 ();

  out_bcd_display #(.DATA_WIDTH(16), .DIGITS(5), .BLANK_LEADING(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  out_bcd_display #(.DATA_WIDTH(16), .DIGITS(5), .BLANK_LEADING(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [34:0] SEG_RST = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};

  // Observe n falling edges on one instance; busy cycles, pulse count, first pulse index/value.
  task automatic watch(input bit sel, input int n, output int busy_n, output int pulses,
                       output int first, output logic [19:0] bcd_first);
    logic b, u;
    logic [19:0] v;
    busy_n = 0; pulses = 0; first = 0; bcd_first = '0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (sel) begin b = bus2.busy; u = bus2.updated; v = bus2.bcd; end
      else     begin b = bus.busy;  u = bus.updated;  v = bus.bcd;  end
      if (b) busy_n++;
      if (u) begin
        pulses++;
        if (first == 0) begin first = i; bcd_first = v; end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.in = '0; bus2.in = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.bcd !== 20'h0) begin errors++; $display("FAIL reset_bcd got %h want %h", bus.bcd, 20'h0); end
    vectors++;
    if (bus.seg !== SEG_RST) begin errors++; $display("FAIL reset_seg got %h want %h", bus.seg, SEG_RST); end
    vectors++;
    if ({bus.busy, bus.updated} !== 2'b00) begin
      errors++; $display("FAIL reset_flags got %b want 00", {bus.busy, bus.updated});
    end
    vectors++;
    if (bus2.seg !== {5{7'h40}}) begin
      errors++; $display("FAIL reset_seg_noblank got %h want %h", bus2.seg, {5{7'h40}});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_convert_1234();
    int bn, pn, fp; logic [19:0] bf;
    bus.in = 16'd1234;
    watch(1'b0, 30, bn, pn, fp, bf);
    vectors++;
    if (bn != 17) begin errors++; $display("FAIL c1234_busy_cycles got %0d want 17", bn); end
    vectors++;
    if (pn != 1 || fp != 18) begin
      errors++; $display("FAIL c1234_pulse got n=%0d at=%0d want n=1 at=18", pn, fp);
    end
    vectors++;
    if (bus.bcd !== 20'h01234) begin errors++; $display("FAIL c1234_bcd got %h want 01234", bus.bcd); end
    vectors++;
    if (bus.seg !== {7'h7F, 7'h79, 7'h24, 7'h30, 7'h19}) begin
      errors++; $display("FAIL c1234_seg got %h want %h", bus.seg, {7'h7F, 7'h79, 7'h24, 7'h30, 7'h19});
    end
    bus.in = 16'd1234;
    watch(1'b0, 10, bn, pn, fp, bf);
    vectors++;
    if (bn != 0 || pn != 0) begin
      errors++; $display("FAIL c1234_hold got busy=%0d pulses=%0d want 0 0", bn, pn);
    end
  endtask

  task automatic test_max_and_zero();
    int bn, pn, fp; logic [19:0] bf;
    bus.in = 16'hFFFF;
    watch(1'b0, 22, bn, pn, fp, bf);
    vectors++;
    if (bus.bcd !== 20'h65535 || fp != 18) begin
      errors++; $display("FAIL max_bcd got %h at=%0d want 65535 at=18", bus.bcd, fp);
    end
    vectors++;
    if (bus.seg !== {7'h02, 7'h12, 7'h12, 7'h30, 7'h12}) begin
      errors++; $display("FAIL max_seg got %h want %h", bus.seg, {7'h02, 7'h12, 7'h12, 7'h30, 7'h12});
    end
    bus.in = 16'h0000;
    watch(1'b0, 22, bn, pn, fp, bf);
    vectors++;
    if (bus.bcd !== 20'h0 || bus.seg !== SEG_RST || pn != 1) begin
      errors++; $display("FAIL zero_out got bcd=%h seg=%h pulses=%0d want 0 %h 1", bus.bcd, bus.seg, pn, SEG_RST);
    end
  endtask

  task automatic test_back_to_back();
    int bn, pn, fp; logic [19:0] bf;
    int bn2, pn2, fp2; logic [19:0] bf2;
    bus.in = 16'd1234;
    watch(1'b0, 5, bn, pn, fp, bf);
    bus.in = 16'd42;
    watch(1'b0, 50, bn2, pn2, fp2, bf2);
    vectors++;
    if (pn + pn2 != 2) begin errors++; $display("FAIL b2b_pulses got %0d want 2", pn + pn2); end
    vectors++;
    if (bf2 !== 20'h01234 || fp2 != 13) begin
      errors++; $display("FAIL b2b_first got %h at=%0d want 01234 at=13", bf2, fp2);
    end
    vectors++;
    if (bus.bcd !== 20'h00042) begin errors++; $display("FAIL b2b_final_bcd got %h want 00042", bus.bcd); end
    vectors++;
    if (bus.seg !== {7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24}) begin
      errors++; $display("FAIL b2b_seg got %h want %h", bus.seg, {7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24});
    end
  endtask

  task automatic test_reset_mid();
    int bn, pn, fp; logic [19:0] bf;
    bus.in = 16'd9999;
    watch(1'b0, 6, bn, pn, fp, bf);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.bcd !== 20'h0 || bus.seg !== SEG_RST || bus.updated !== 1'b0) begin
      errors++; $display("FAIL midreset got busy=%b bcd=%h seg=%h upd=%b want 0 0 %h 0",
                         bus.busy, bus.bcd, bus.seg, bus.updated, SEG_RST);
    end
    @(negedge clk);
    rst_n = 1'b1;
    watch(1'b0, 25, bn, pn, fp, bf);
    vectors++;
    if (bus.bcd !== 20'h09999 || fp != 18 || pn != 1) begin
      errors++; $display("FAIL midreset_redo got %h at=%0d n=%0d want 09999 at=18 n=1", bus.bcd, fp, pn);
    end
    vectors++;
    if (bus.seg !== {7'h7F, 7'h10, 7'h10, 7'h10, 7'h10}) begin
      errors++; $display("FAIL midreset_seg got %h want %h", bus.seg, {7'h7F, 7'h10, 7'h10, 7'h10, 7'h10});
    end
  endtask

  task automatic test_no_blank();
    int bn, pn, fp; logic [19:0] bf;
    bus2.in = 16'd7;
    watch(1'b1, 25, bn, pn, fp, bf);
    vectors++;
    if (bus2.bcd !== 20'h00007 || fp != 18) begin
      errors++; $display("FAIL noblank_bcd got %h at=%0d want 00007 at=18", bus2.bcd, fp);
    end
    vectors++;
    if (bus2.seg !== {7'h40, 7'h40, 7'h40, 7'h40, 7'h78}) begin
      errors++; $display("FAIL noblank_seg got %h want %h", bus2.seg, {7'h40, 7'h40, 7'h40, 7'h40, 7'h78});
    end
    bus2.in = 16'd7;
    watch(1'b1, 10, bn, pn, fp, bf);
    vectors++;
    if (bn != 0 || pn != 0) begin
      errors++; $display("FAIL noblank_rewrite got busy=%0d pulses=%0d want 0 0", bn, pn);
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    test_reset();
    test_convert_1234();
    test_max_and_zero();
    test_back_to_back();
    test_reset_mid();
    test_no_blank();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
